// File: rtl/riscv_result_monitor.sv
// rtl/riscv_result_monitor.sv - result-region checker and performance monitor for the RISC-V core bench
//
// Purpose:
//   Snoops data-memory writes, captures a window of REGION_LEN words starting
//   at REGION_BASE (byte order reversed so the stored word is readable), and
//   on a write to END_ADDR walks the window one entry per cycle comparing it
//   against a golden table loaded through gold_*. Saturating counters track
//   run length, stalls, flushes and instruction-address changes; a watchdog
//   ends the run after TIMEOUT_CYC cycles (0 disables it).
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   wen, addr, data     data-memory write snoop (word address, little-endian data)
//   stall, flush        core stall / pipeline flush indicators
//   I_addr              instruction fetch address
//   gold_wen/idx/data   golden table write port (accepted only while running)
//   finish, pass        run complete / complete with no errors and no timeout
//   timeout             watchdog fired
//   error_num           number of mismatching entries (saturating)
//   duration, stall_cycles, flush_times, instr_count   performance counters
//   first_err_idx/exp/got  first mismatch details
//
// Optional feature macro: RESULT_MON_FIRST_ERR_EN
//   Defined   - first mismatch index, golden and captured value are latched.
//   Undefined - first_err_* outputs are constant 0.

module riscv_result_monitor #(
    parameter int ADDR_W      = 30,
    parameter int DATA_W      = 32,
    parameter int CNT_W       = 16,
    parameter int ERR_W       = 8,
    parameter int REGION_BASE = 128,
    parameter int REGION_LEN  = 8,
    parameter int END_ADDR    = 255,
    parameter int TIMEOUT_CYC = 50000,
    localparam int IDX_W      = (REGION_LEN > 1) ? $clog2(REGION_LEN) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wen,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] I_addr,
    input  logic              gold_wen,
    input  logic [IDX_W-1:0]  gold_idx,
    input  logic [DATA_W-1:0] gold_data,
    output logic              finish,
    output logic              pass,
    output logic              timeout,
    output logic [ERR_W-1:0]  error_num,
    output logic [CNT_W-1:0]  duration,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_times,
    output logic [CNT_W-1:0]  instr_count,
    output logic [IDX_W-1:0]  first_err_idx,
    output logic [DATA_W-1:0] first_err_exp,
    output logic [DATA_W-1:0] first_err_got
);

    localparam int NBYTES = DATA_W / 8;

    localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(REGION_BASE);
    localparam logic [ADDR_W-1:0] LEN_A   = ADDR_W'(REGION_LEN);
    localparam logic [ADDR_W-1:0] END_A   = ADDR_W'(END_ADDR);
    localparam logic [IDX_W:0]    LEN_I   = (IDX_W + 1)'(REGION_LEN);
    localparam logic [IDX_W-1:0]  LAST_I  = IDX_W'(REGION_LEN - 1);

    // A limit the counter can never represent simply never fires.
    localparam bit WD_EN = (TIMEOUT_CYC != 0) &&
                           ((CNT_W >= 31) || (TIMEOUT_CYC < (1 << CNT_W)));
    localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_CMP  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    duration_q, duration_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0]    instr_cnt_q, instr_cnt_d;
    logic [ADDR_W-1:0]   prev_iaddr_q, prev_iaddr_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic                finish_q, finish_d;
    logic                pass_q, pass_d;
    logic                timeout_q, timeout_d;
    logic [IDX_W-1:0]    cmp_idx_q, cmp_idx_d;
    logic [DATA_W-1:0]   cap_q  [REGION_LEN];
    logic [DATA_W-1:0]   cap_d  [REGION_LEN];
    logic [DATA_W-1:0]   gold_q [REGION_LEN];
    logic [DATA_W-1:0]   gold_d [REGION_LEN];

    logic [DATA_W-1:0]   swapped;
    logic [ADDR_W-1:0]   region_off;
    logic                in_region;
    logic                gold_ok;
    logic                end_hit;
    logic                wd_hit;
    logic                mismatch;
    logic [CNT_W-1:0]    duration_inc;

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Byte 0 of the core's little-endian word becomes the MSB of the stored word.
    always_comb begin
        swapped = '0;
        for (int b = 0; b < NBYTES; b++) begin
            swapped[8*b +: 8] = data[DATA_W-8-8*b +: 8];
        end
    end

    // Subtracting first keeps the range test free of BASE+LEN overflow.
    assign region_off   = addr - BASE_A;
    assign in_region    = (addr >= BASE_A) && (region_off < LEN_A);
    assign gold_ok      = ({1'b0, gold_idx} < LEN_I);
    assign end_hit      = wen && (addr == END_A);
    assign duration_inc = cnt_inc(duration_q);
    assign wd_hit       = WD_EN && (duration_inc == WD_LIMIT);
    assign mismatch     = (cap_q[cmp_idx_q] != gold_q[cmp_idx_q]);

    always_comb begin
        state_d      = state_q;
        duration_d   = duration_q;
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        instr_cnt_d  = instr_cnt_q;
        prev_iaddr_d = prev_iaddr_q;
        err_d        = err_q;
        finish_d     = finish_q;
        pass_d       = pass_q;
        timeout_d    = timeout_q;
        cmp_idx_d    = cmp_idx_q;
        cap_d        = cap_q;
        gold_d       = gold_q;

        case (state_q)
            ST_RUN: begin
                duration_d = duration_inc;
                if (stall) begin
                    stall_cnt_d = cnt_inc(stall_cnt_q);
                end
                if (flush) begin
                    flush_cnt_d = cnt_inc(flush_cnt_q);
                end
                if (I_addr != prev_iaddr_q) begin
                    instr_cnt_d = cnt_inc(instr_cnt_q);
                end
                prev_iaddr_d = I_addr;

                if (wen && in_region) begin
                    cap_d[region_off[IDX_W-1:0]] = swapped;
                end
                if (gold_wen && gold_ok) begin
                    gold_d[gold_idx] = gold_data;
                end

                // The end write takes priority over a watchdog expiring on the same cycle.
                if (end_hit) begin
                    state_d   = ST_CMP;
                    cmp_idx_d = '0;
                end else if (wd_hit) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                end
            end

            ST_CMP: begin
                if (mismatch && !(&err_q)) begin
                    err_d = err_q + ERR_W'(1);
                end
                if (cmp_idx_q == LAST_I) begin
                    state_d = ST_DONE;
                end else begin
                    cmp_idx_d = cmp_idx_q + IDX_W'(1);
                end
            end

            ST_DONE: begin
                // Registered one cycle after entry so the final error count is settled.
                finish_d = 1'b1;
                pass_d   = (err_q == '0) && !timeout_q;
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_RUN;
            duration_q   <= '0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            instr_cnt_q  <= '0;
            prev_iaddr_q <= '0;
            err_q        <= '0;
            finish_q     <= 1'b0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
            cmp_idx_q    <= '0;
            for (int i = 0; i < REGION_LEN; i++) begin
                cap_q[i]  <= '0;
                gold_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            duration_q   <= duration_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            instr_cnt_q  <= instr_cnt_d;
            prev_iaddr_q <= prev_iaddr_d;
            err_q        <= err_d;
            finish_q     <= finish_d;
            pass_q       <= pass_d;
            timeout_q    <= timeout_d;
            cmp_idx_q    <= cmp_idx_d;
            for (int i = 0; i < REGION_LEN; i++) begin
                cap_q[i]  <= cap_d[i];
                gold_q[i] <= gold_d[i];
            end
        end
    end

`ifdef RESULT_MON_FIRST_ERR_EN
    logic [IDX_W-1:0]  fe_idx_q, fe_idx_d;
    logic [DATA_W-1:0] fe_exp_q, fe_exp_d;
    logic [DATA_W-1:0] fe_got_q, fe_got_d;

    // Only the mismatch seen while the error count is still zero is recorded.
    always_comb begin
        fe_idx_d = fe_idx_q;
        fe_exp_d = fe_exp_q;
        fe_got_d = fe_got_q;
        if ((state_q == ST_CMP) && mismatch && (err_q == '0)) begin
            fe_idx_d = cmp_idx_q;
            fe_exp_d = gold_q[cmp_idx_q];
            fe_got_d = cap_q[cmp_idx_q];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fe_idx_q <= '0;
            fe_exp_q <= '0;
            fe_got_q <= '0;
        end else begin
            fe_idx_q <= fe_idx_d;
            fe_exp_q <= fe_exp_d;
            fe_got_q <= fe_got_d;
        end
    end

    assign first_err_idx = fe_idx_q;
    assign first_err_exp = fe_exp_q;
    assign first_err_got = fe_got_q;
`else
    assign first_err_idx = '0;
    assign first_err_exp = '0;
    assign first_err_got = '0;
`endif

    assign finish       = finish_q;
    assign pass         = pass_q;
    assign timeout      = timeout_q;
    assign error_num    = err_q;
    assign duration     = duration_q;
    assign stall_cycles = stall_cnt_q;
    assign flush_times  = flush_cnt_q;
    assign instr_count  = instr_cnt_q;

endmodule

// File: doc/riscv_result_monitor.md
Name: riscv_result_monitor

Overview:
- Parametrised, synthesizable result checker and performance monitor for the RISC-V core bench.
- Snoops data-memory writes and captures a configurable result region. On a write to a terminator address it compares that region against golden values, one entry per cycle.
- Maintains saturating performance counters (cycles, stalls, flushes, instructions) and raises finish/pass, with a watchdog timeout.

Parameters:
- ADDR_W, 30, word-address width of addr and I_addr
- DATA_W, 32, data width; multiple of 8
- CNT_W, 16, width of every performance counter
- ERR_W, 8, width of error_num
- REGION_BASE, 128, first word address of the result region
- REGION_LEN, 8, number of words in the result region (>=1)
- END_ADDR, 255, write to this address ends the run; must lie outside the region
- TIMEOUT_CYC, 50000, run cycles before watchdog fires; 0 disables it

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- wen  in  1  data-memory write enable
- addr  in  ADDR_W  data-memory word address
- data  in  DATA_W  write data, little-endian byte order
- stall  in  1  core memory stall
- flush  in  1  pipeline flush
- I_addr  in  ADDR_W  instruction fetch address
- gold_wen  in  1  golden-table write strobe
- gold_idx  in  clog2(REGION_LEN) (min 1)  golden entry index
- gold_data  in  DATA_W  golden value, readable byte order
- finish  out  1  run complete
- pass  out  1  finish with zero errors and no timeout
- timeout  out  1  watchdog fired
- error_num  out  ERR_W  mismatch count
- duration  out  CNT_W  cycles spent in RUN
- stall_cycles  out  CNT_W  RUN cycles with stall=1
- flush_times  out  CNT_W  RUN cycles with flush=1
- instr_count  out  CNT_W  changes of I_addr during RUN
- first_err_idx  out  clog2(REGION_LEN)  optional; see below
- first_err_exp  out  DATA_W  optional
- first_err_got  out  DATA_W  optional

Behaviour:
- Reset (rst=0, asynchronous):
  - state=RUN.
  - All outputs, counters, captured region, golden table, prev_I_addr, and compare index are 0.
- Byte order: captured word = data with byte order reversed (byte0 becomes MSB). Golden values are stored as given.
- States:
  - RUN
  - CMP
  - DONE
- RUN, every cycle:
  - duration+1.
  - stall_cycles+1 if stall; flush_times+1 if flush.
  - instr_count+1 if I_addr != prev_I_addr; prev_I_addr <= I_addr.
  - All counters saturate at all-ones.
- RUN capture: wen with REGION_BASE <= addr < REGION_BASE+REGION_LEN writes the swapped word to entry addr-REGION_BASE. Any later write to the same address overwrites. Writes to other addresses are ignored.
- RUN -> CMP: on wen with addr==END_ADDR. Counters include that cycle. Compare index is set to 0.
- RUN -> DONE (watchdog): when TIMEOUT_CYC != 0 and duration reaches TIMEOUT_CYC. timeout=1; error_num is unchanged.
- Simultaneous end write and timeout in the same cycle: the end write wins and the state goes to CMP.
- CMP:
  - Each cycle compares captured[idx] against golden[idx]; on mismatch error_num+1 (saturating), then idx+1.
  - After idx=REGION_LEN-1 the state goes to DONE. CMP lasts exactly REGION_LEN cycles.
  - finish rises on the clock edge REGION_LEN+1 after the edge that samples the end write.
- DONE:
  - finish=1; pass = (error_num==0) && !timeout; both registered.
  - All counters and the region freeze; the state holds until reset.
- Snoop writes and golden writes during CMP/DONE are ignored.
- gold_wen is accepted only in RUN. gold_idx >= REGION_LEN is ignored.
- Reset during CMP/DONE returns the block to the RUN reset state immediately.

Optional Feature:
- Macro RESULT_MON_FIRST_ERR_EN.
- Defined:
  - On the first mismatch in CMP (error_num was 0), latch idx, golden value and captured value into first_err_idx/first_err_exp/first_err_got.
  - Later mismatches do not update these registers; they hold until reset.
- Undefined: the three ports are tied to 0 and no latch registers exist.

Test Plan:
- Golden 1..8 loaded; core writes little-endian 1..8 to addr 128..135, then wen addr 255 at run cycle 40 -> finish at run cycle 49 (REGION_LEN+1=9 edges later), pass=1, error_num=0, duration=40.
- Same run but addr 131 written with value 99 -> error_num=1, pass=0. With macro: first_err_idx=3, first_err_exp=4, first_err_got=99.
- Stall high 10 cycles, flush pulsed 3 times, I_addr incremented by 1 for 20 cycles then held -> stall_cycles=10, flush_times=3, instr_count=20.
- TIMEOUT_CYC=100, end address never written -> finish at duration=100, timeout=1, pass=0. Counters then stop.
- Writes to 127, 136 and 300 before the end write -> region unaffected. Double write to 128 (5, then 1) -> last value 1 is compared.
- rst pulsed low during CMP -> outputs all 0 asynchronously. Fresh run after release passes.
